// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: DEPTH stages of {valid, data} with valid/ready
// handshake, bubble collapsing, global stall, per-stage squash and a saturating squash counter.
module pipe_stage_chain #(
  parameter int                WIDTH   = 32,
  parameter int                DEPTH   = 4,
  parameter logic [WIDTH-1:0]  NOP_VAL = '0,
  parameter int                CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic                         stall,
  input  logic [DEPTH-1:0]             flush_mask,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             squash_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CNT_W-1:0] r_squash_cnt;

  logic [DEPTH-1:0] w_eff_valid;
  logic [DEPTH:0]   w_ready;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic [OCC_W-1:0] w_occ;
  logic [OCC_W-1:0] w_sq_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;

  // A squashed item no longer counts as live, so its slot reads as free this cycle.
  assign w_eff_valid = r_valid & ~flush_mask;

  always_comb begin
    w_ready        = '0;
    w_ready[DEPTH] = out_ready & ~stall;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_ready[i] = ~stall & (~w_eff_valid[i] | w_ready[i+1]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign w_src_valid[gi] = in_valid;
        assign w_src_data[gi]  = in_data;
      end else begin : g_body
        assign w_src_valid[gi] = w_eff_valid[gi-1];
        assign w_src_data[gi]  = r_data[gi-1];
      end
    end
  endgenerate

  // Load beats squash: a vacated slot may take the upstream item on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= NOP_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ready[i]) begin
          r_valid[i] <= w_src_valid[i];
          r_data[i]  <= w_src_data[i];
        end else if (flush_mask[i]) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= NOP_VAL;
        end
      end
    end
  end

  always_comb begin
    w_occ    = '0;
    w_sq_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ    = w_occ + OCC_W'(r_valid[i]);
      w_sq_pop = w_sq_pop + OCC_W'(r_valid[i] & flush_mask[i]);
    end
  end

  // Any carry above CNT_W means the true count no longer fits: pin at all-ones.
  assign w_sum      = SUM_W'(r_squash_cnt) + SUM_W'(w_sq_pop);
  assign w_cnt_next = (|w_sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_squash_cnt <= '0;
    end else begin
      r_squash_cnt <= w_cnt_next;
    end
  end

  assign in_ready   = w_ready[0] & ~rst;
  assign out_valid  = w_eff_valid[DEPTH-1];
  assign out_data   = r_data[DEPTH-1];
  assign occupancy  = w_occ;
  assign squash_cnt = r_squash_cnt;

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised elastic pipeline-register chain that replaces the fixed-width, always-loading inter-stage latches of the MIPS datapath. It carries an instruction word or decoded-field bundle through DEPTH registered stages with per-stage valid bits, a valid/ready handshake, bubble collapsing, a global stall and per-stage squash. It also reports occupancy and a saturating count of squashed items. One instance sits between each pair of pipeline stages, for example IF→ID or ID→EX.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- NOP_VAL, 32'h0000_0000, payload value loaded on reset and into squashed stages; MIPS `sll $0,$0,0`
- CNT_W, 16, width of the squash counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream item present
- in_data  in  WIDTH  upstream payload
- in_ready  out  1  chain accepts in_data this cycle
- out_valid  out  1  stage DEPTH-1 holds a live item
- out_data  out  WIDTH  payload of stage DEPTH-1
- out_ready  in  1  downstream accepts this cycle
- stall  in  1  global hold; no stage loads
- flush_mask  in  DEPTH  bit i squashes the item currently in stage i
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered state)
- squash_cnt  out  CNT_W  saturating count of live items squashed

## Operation
- State per stage i: v[i] (1 bit), d[i] (WIDTH bits). Stage 0 is the input side; stage DEPTH-1 is the output.
- Effective valid: ev[i] = v[i] & ~flush_mask[i].
- Ready chain (combinational, output to input):
  - r[DEPTH] = out_ready & ~stall
  - r[i] = ~stall & (~ev[i] | r[i+1])
  - in_ready = r[0] & ~rst
- out_valid = ev[DEPTH-1]; out_data = d[DEPTH-1].
- Update per stage each edge, in priority order:
  1. rst → v=0, d=NOP_VAL.
  2. r[i] → v[i] ← ev[i-1], d[i] ← d[i-1]. For stage 0, use in_valid and in_data as the source. A bubble propagates as v=0 with its data copied.
  3. else if flush_mask[i] → v[i] ← 0, d[i] ← NOP_VAL.
  4. else hold.
- A squashed item vacates its slot in the same cycle, so an upstream item may advance into it on that edge.
- Bubble collapsing: an empty stage always loads unless stall=1, even when downstream is blocked.
- A transfer occurs on an edge where in_valid & in_ready (input side) or out_valid & out_ready & ~stall (output side). Items are never duplicated or reordered.
- stall=1 freezes every v and d except squashed stages. in_ready=0 and the output does not complete a transfer.
- occupancy = popcount(v), from registered v, so it does not reflect this cycle's flush_mask.
- squash_cnt increments by popcount(v & flush_mask) each cycle and saturates at 2^CNT_W−1. It does not wrap.
- DEPTH=1: the chain degenerates to a single handshake register with the same rules.

## Timing
- Latency: an item accepted at edge N appears on out_valid after edge N+DEPTH−1 when no blocking occurs (DEPTH register stages).
- Throughput: 1 item/cycle sustained when out_ready=1 and stall=0.
- in_ready depends combinationally on out_ready, stall and flush_mask through the full chain. This is a deliberate trade for full throughput with no skid buffer.
- Reset is asynchronous on assert. Values after reset:
  - out_valid=0, out_data=NOP_VAL
  - occupancy=0, squash_cnt=0
  - in_ready=0 while rst=1
- Release of rst is synchronised by the integrating design. Reset mid-operation discards all items and does not count them as squashed.
- Boundary: chain full with out_ready=0 → in_ready=0. Chain full with out_ready=1 → in_ready=1, and the whole chain shifts together.
- flush_mask=all-ones together with in_valid=1 and stall=0: all held items are dropped, and the new input is accepted into stage 0.

## Test plan
- Reset, then streaming: pulse rst, then 8 items 0x11..0x18 with out_ready=1 and DEPTH=4 → first out_valid 3 cycles after the first accept, items in order, no gaps, occupancy peaks at 4.
- Back-pressure: fill with 0xA0..0xA3 and hold out_ready=0 for 5 cycles → in_ready=0 and occupancy=4, data held; raise out_ready → 0xA0..0xA3 drain one per cycle.
- Bubble collapse: items 0x1 and 0x2 with a 2-cycle in_valid gap, out_ready=0 → both items compact into stages 3 and 2, and occupancy=2.
- Squash: chain holds 0xB0..0xB3 and flush_mask=4'b0011 for one cycle → 0xB3 and 0xB2 never appear at the output, squash_cnt=2, and the stage 0 slot refills in the same cycle from in_data.
- Stall override: stall=1 with out_ready=1 and in_valid=1 for 3 cycles → no transfers, state frozen; stall=1 with flush_mask=4'b1000 → stage 3 cleared, out_valid=0.
- Counter saturation: CNT_W=2 with 5 single-item squashes → squash_cnt holds at 3.
